// File: rtl/systolic_mac_top.sv
// 2x2 output-stationary systolic matrix-multiply engine: one packed job in,
// C = A x B streamed out as two 64-bit beats under a ready handshake.
`timescale 1ns/1ps
module systolic_mac_top #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        ready,
  input  logic [63:0] data_in,
  output logic        tx_done,
  output logic [63:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_BUF, S_TX} state_e;
  typedef logic [DATA_W-1:0]   elem_t;
  typedef logic [ACC_W-1:0]    acc_t;
  typedef logic [2*DATA_W-1:0] prod_t;

  state_e             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic               beat_q, beat_d;
  logic [63:0]        op_q, op_d;
  logic               tx_done_q, tx_done_d;
  logic [4*ACC_W-1:0] res_buf_q, res_buf_d;

  elem_t [N-1:0][N-1:0] a_m, b_m;
  elem_t [N-1:0]        row_in, col_in;
  // Only column 0 forwards a and row 0 forwards b to a PE that consumes it.
  elem_t [N-1:0]        a_pipe_q, a_pipe_d;
  elem_t [N-1:0]        b_pipe_q, b_pipe_d;
  elem_t [N-1:0][N-1:0] pe_a, pe_b;
  prod_t [N-1:0][N-1:0] prod;
  acc_t  [N-1:0][N-1:0] acc_q, acc_d;
  logic                 step;

  // Packed [row][col] view of the operand word, bytes LSB first.
  assign a_m  = op_q[31:0];
  assign b_m  = op_q[63:32];
  assign step = (state_q == S_COMPUTE);

  // Skewed feed: row i carries A[i][k-i], column j carries B[k-j][j].
  always_comb begin
    row_in = '0;
    col_in = '0;
    if (step) begin
      case (k_q)
        2'd0: begin
          row_in[0] = a_m[0][0];
          col_in[0] = b_m[0][0];
        end
        2'd1: begin
          row_in[0] = a_m[0][1];
          row_in[1] = a_m[1][0];
          col_in[0] = b_m[1][0];
          col_in[1] = b_m[0][1];
        end
        2'd2: begin
          row_in[1] = a_m[1][1];
          col_in[1] = b_m[1][1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pe_a[0][0] = row_in[0];
    pe_a[0][1] = a_pipe_q[0];
    pe_a[1][0] = row_in[1];
    pe_a[1][1] = a_pipe_q[1];
    pe_b[0][0] = col_in[0];
    pe_b[0][1] = col_in[1];
    pe_b[1][0] = b_pipe_q[0];
    pe_b[1][1] = b_pipe_q[1];
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = prod_t'(pe_a[i][j]) * prod_t'(pe_b[i][j]);
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch leaves a signal unassigned
    // and no latch is inferred.
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    op_d      = op_q;
    tx_done_d = 1'b0;
    res_buf_d = res_buf_q;
    a_pipe_d  = a_pipe_q;
    b_pipe_d  = b_pipe_q;
    acc_d     = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          op_d     = data_in;
          k_d      = '0;
          acc_d    = '0;
          a_pipe_d = '0;
          b_pipe_d = '0;
          state_d  = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        a_pipe_d = row_in;
        b_pipe_d = col_in;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            acc_d[i][j] = acc_q[i][j] + acc_t'(prod[i][j]);
          end
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_BUF;
      end
      S_BUF: begin
        res_buf_d = {acc_q[1][1], acc_q[1][0], acc_q[0][1], acc_q[0][0]};
        beat_d    = 1'b0;
        state_d   = S_TX;
      end
      S_TX: begin
        if (ready) begin
          if (beat_q) begin
            beat_d    = 1'b0;
            tx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            beat_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: datapath storage is cleared along with control so an aborted job
      // leaves no stale results behind.
      state_q   <= S_IDLE;
      k_q       <= '0;
      beat_q    <= 1'b0;
      op_q      <= '0;
      tx_done_q <= 1'b0;
      res_buf_q <= '0;
      a_pipe_q  <= '0;
      b_pipe_q  <= '0;
      acc_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q   <= state_d;
      k_q       <= k_d;
      beat_q    <= beat_d;
      op_q      <= op_d;
      tx_done_q <= tx_done_d;
      res_buf_q <= res_buf_d;
      a_pipe_q  <= a_pipe_d;
      b_pipe_q  <= b_pipe_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (state_q == S_TX) data_out = beat_q ? res_buf_q[127:64] : res_buf_q[63:0];
  end

  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_systolic_mac_top.sv
// Scoreboard bench for systolic_mac_top: stimulus queues expected beats and
// tx_done pulses, a negedge monitor pops and compares each observed transfer.
`timescale 1ns/1ps
module tb_systolic_mac_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [63:0] data_in;
  logic        tx_done;
  logic [63:0] data_out;

  systolic_mac_top #(.N(2), .DATA_W(8), .ACC_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .ready    (ready),
    .data_in  (data_in),
    .tx_done  (tx_done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] JOB_BASIC = 64'h0807060504030201;
  localparam logic [63:0] BASIC_B0  = 64'h00000016_00000013;
  localparam logic [63:0] BASIC_B1  = 64'h00000032_0000002B;
  localparam logic [63:0] JOB_LARGE = 64'hCAFEBABEDEADBEEF;
  localparam logic [63:0] LARGE_B0  = 64'h00014392_00016DE6;
  localparam logic [63:0] LARGE_B1  = 64'h00012CDE_00015CAA;
  localparam logic [63:0] JOB_MAX   = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] MAX_B     = 64'h0001FC02_0001FC02;
  localparam logic [63:0] JOB_OTHER = 64'h0101010101010101;
  localparam logic [64:0] DONE_ITEM = {1'b1, 64'h0};

  // Item = {tx_done, data_out} as the monitor will see it.
  logic [64:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic expect_job(input logic [63:0] b0, input logic [63:0] b1);
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b0, b1});
    exp_q.push_back(DONE_ITEM);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at accept edge + 1.
  task automatic start_job(input logic [63:0] d);
    valid   = 1'b1;
    data_in = d;
    tick(1);
    valid   = 1'b0;
    data_in = 64'h0;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    #1;
    check("async_rst_data_out", {1'b0, data_out}, 65'h0);
    check("async_rst_tx_done", 65'(tx_done), 65'h0);
    tick(1);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: a beat transfers when data_out is presented with ready high.
  initial begin
    logic [64:0] obs;
    logic [64:0] want;
    forever begin
      @(negedge clk);
      if (!reset && (tx_done || (data_out != 64'h0 && ready))) begin
        obs = {tx_done, data_out};
        if (exp_q.size() == 0) begin
          check("unexpected_output", obs, 65'h0);
        end else begin
          want = exp_q.pop_front();
          check("scoreboard_item", obs, want);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    ready   = 1'b1;
    data_in = 64'h0;
    @(posedge clk);
    #1;
    check("reset_data_out", {1'b0, data_out}, 65'h0);
    check("reset_tx_done", 65'(tx_done), 65'h0);
    tick(1);
    reset = 1'b0;

    // Reset during COMPUTE.
    start_job(JOB_BASIC);
    tick(2);
    apply_reset();

    // Reset mid-TX while the sink stalls.
    ready = 1'b0;
    start_job(JOB_LARGE);
    tick(5);
    check("pre_reset_beat0", {1'b0, data_out}, {1'b0, LARGE_B0});
    apply_reset();
    ready = 1'b1;
    tick(2);
    check("post_reset_idle", {tx_done, data_out}, 65'h0);

    // Basic job with latency checks.
    expect_job(BASIC_B0, BASIC_B1);
    start_job(JOB_BASIC);
    tick(4);
    check("basic_not_early", {tx_done, data_out}, 65'h0);
    tick(1);
    check("basic_latency_beat0", {1'b0, data_out}, {1'b0, BASIC_B0});
    tick(1);
    check("basic_beat1", {1'b0, data_out}, {1'b0, BASIC_B1});
    tick(1);
    check("basic_tx_done", {tx_done, data_out}, DONE_ITEM);
    tick(1);
    check("tx_done_one_cycle", 65'(tx_done), 65'h0);

    // Large operands.
    expect_job(LARGE_B0, LARGE_B1);
    start_job(JOB_LARGE);
    tick(7);
    check("large_tx_done", {tx_done, data_out}, DONE_ITEM);
    tick(1);

    // Backpressure.
    ready = 1'b0;
    expect_job(BASIC_B0, BASIC_B1);
    start_job(JOB_BASIC);
    tick(5);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_beat0", {tx_done, data_out}, {1'b0, BASIC_B0});
      tick(1);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_beat1", {tx_done, data_out}, {1'b0, BASIC_B1});
      tick(1);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("bp_tx_done", {tx_done, data_out}, DONE_ITEM);
    ready = 1'b1;
    tick(1);

    // valid pulses during COMPUTE and TX are ignored.
    expect_job(BASIC_B0, BASIC_B1);
    start_job(JOB_BASIC);
    tick(1);
    valid   = 1'b1;
    data_in = JOB_OTHER;
    tick(1);
    valid   = 1'b0;
    data_in = 64'h0;
    tick(3);
    check("ignored_beat0", {1'b0, data_out}, {1'b0, BASIC_B0});
    valid   = 1'b1;
    data_in = JOB_OTHER;
    tick(1);
    valid   = 1'b0;
    data_in = 64'h0;
    check("ignored_beat1", {1'b0, data_out}, {1'b0, BASIC_B1});
    tick(1);
    check("ignored_tx_done", {tx_done, data_out}, DONE_ITEM);
    tick(1);
    for (int c = 0; c < 8; c++) begin
      check("no_extra_job", {tx_done, data_out}, 65'h0);
      tick(1);
    end

    // Max operands, back-to-back with valid held high.
    expect_job(MAX_B, MAX_B);
    expect_job(MAX_B, MAX_B);
    valid   = 1'b1;
    data_in = JOB_MAX;
    tick(1);
    tick(7);
    check("b2b_first_done", {tx_done, data_out}, DONE_ITEM);
    tick(1);
    valid   = 1'b0;
    data_in = 64'h0;
    tick(5);
    check("b2b_second_latency", {1'b0, data_out}, {1'b0, MAX_B});
    tick(2);
    check("b2b_second_done", {tx_done, data_out}, DONE_ITEM);
    tick(3);

    check("scoreboard_drained", 65'(exp_q.size()), 65'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
